// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock over WIDTH+1 iterations,
// handling signed and unsigned operands by extending both to WIDTH+1 bits on acceptance.
module booth_multiplier_seq #(
   parameter int WIDTH = 9
) (
   input  logic                 Clk,
   input  logic                 Reset_n,
   input  logic                 Start,
   input  logic                 Signed_Mode,
   input  logic [WIDTH-1:0]     Data_A,
   input  logic [WIDTH-1:0]     Data_B,
   output logic                 Busy,
   output logic                 Done,
   output logic [2*WIDTH-1:0]   Product
);

   localparam int XW    = WIDTH + 1;
   localparam int CNT_W = $clog2(WIDTH + 2);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                  state, state_next;
   logic signed [XW-1:0]    acc, mcand, acc_sum, acc_shift;
   logic [XW-1:0]           q, q_shift, a_ext;
   logic signed [XW-1:0]    b_ext;
   logic                    q_m1, q_m1_shift;
   logic [CNT_W-1:0]        count;
   logic                    last_iter;

   // Add/subtract selected by the Booth pair {Q0, Q_-1}; wraps modulo 2^(WIDTH+1).
   function automatic logic signed [XW-1:0] booth_add(
      input logic signed [XW-1:0] a,
      input logic signed [XW-1:0] m,
      input logic [1:0]           pair
   );
      case (pair)
         2'b01:   return a + m;
         2'b10:   return a + (~m) + XW'(1);
         default: return a;
      endcase
   endfunction

   assign a_ext = Signed_Mode ? {Data_A[WIDTH-1], Data_A} : {1'b0, Data_A};
   assign b_ext = Signed_Mode ? {Data_B[WIDTH-1], Data_B} : {1'b0, Data_B};

   assign acc_sum    = booth_add(acc, mcand, {q[0], q_m1});
   assign acc_shift  = {acc_sum[XW-1], acc_sum[XW-1:1]};
   assign q_shift    = {acc_sum[0], q[XW-1:1]};
   assign q_m1_shift = q[0];
   assign last_iter  = (count == CNT_W'(1));

   assign Busy = (state != IDLE);
   assign Done = (state == DONE);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (Start) state_next = CALC;
         CALC:    if (last_iter) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         acc     <= '0;
         mcand   <= '0;
         q       <= '0;
         q_m1    <= 1'b0;
         count   <= '0;
         Product <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  acc   <= '0;
                  q     <= a_ext;
                  mcand <= b_ext;
                  q_m1  <= 1'b0;
                  count <= CNT_W'(XW);
               end
            end
            CALC: begin
               acc   <= acc_shift;
               q     <= q_shift;
               q_m1  <= q_m1_shift;
               count <= count - CNT_W'(1);
               // The final shift result goes straight to Product on the completion edge.
               if (last_iter) begin
                  Product <= {acc_shift[WIDTH-2:0], q_shift};
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Bench for booth_multiplier_seq: directed WIDTH=9 cases plus a randomized WIDTH=16 sweep
// on four parallel lanes, all compared against an integer-arithmetic product model.
module tb_booth_multiplier_seq;

   localparam int LANES = 4;
   localparam int OPS16 = 2500;

   logic clk;
   logic rst_n;

   logic        start9, sm9, busy9, done9;
   logic [8:0]  a9, b9;
   logic [17:0] p9;

   logic        start16;
   logic        sm16   [LANES];
   logic [15:0] a16    [LANES];
   logic [15:0] b16    [LANES];
   logic        busy16 [LANES];
   logic        done16 [LANES];
   logic [31:0] p16    [LANES];

   int n_chk  = 0;
   int n_fail = 0;

   booth_multiplier_seq #(.WIDTH(9)) u_dut9 (
      .Clk(clk), .Reset_n(rst_n), .Start(start9), .Signed_Mode(sm9),
      .Data_A(a9), .Data_B(b9), .Busy(busy9), .Done(done9), .Product(p9)
   );

   genvar g;
   generate
      for (g = 0; g < LANES; g++) begin : g_lane
         booth_multiplier_seq #(.WIDTH(16)) u_dut16 (
            .Clk(clk), .Reset_n(rst_n), .Start(start16), .Signed_Mode(sm16[g]),
            .Data_A(a16[g]), .Data_B(b16[g]), .Busy(busy16[g]), .Done(done16[g]),
            .Product(p16[g])
         );
      end
   endgenerate

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Exact product of two w-bit operands, reduced to 2w bits.
   function automatic logic [63:0] ref_mul(input int w, input logic sm,
                                           input logic [31:0] a, input logic [31:0] b);
      longint x, y, p;
      x = longint'(a);
      y = longint'(b);
      if (sm && a[w-1]) x = x - (longint'(1) << w);
      if (sm && b[w-1]) y = y - (longint'(1) << w);
      p = x * y;
      return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
   endfunction

   // One WIDTH=9 multiply, started #1 after a rising edge.
   task automatic run9(input string tag, input logic sm, input logic [8:0] a,
                       input logic [8:0] b, input logic [17:0] exp);
      int          cyc;
      logic        stable;
      logic [17:0] prev;
      sm9 = sm; a9 = a; b9 = b; start9 = 1'b1;
      prev = p9;
      @(posedge clk); #1;
      start9 = 1'b0;
      cyc = 0;
      stable = 1'b1;
      while (!done9 && cyc < 40) begin
         if (p9 !== prev) stable = 1'b0;
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, "_latency"}, 64'(cyc), 64'd10);
      chk({tag, "_product"}, 64'(p9), 64'(exp));
      chk({tag, "_model"}, 64'(p9), ref_mul(9, sm, 32'(a), 32'(b)));
      chk({tag, "_stable"}, 64'(stable), 64'd1);
      @(posedge clk); #1;
      chk({tag, "_idle"}, {62'd0, busy9, done9}, 64'd0);
   endtask

   initial begin
      int          cyc, npulse;
      logic [17:0] got;
      logic [63:0] exp16 [LANES];

      rst_n = 1'b0;
      start9 = 1'b0; sm9 = 1'b0; a9 = '0; b9 = '0;
      start16 = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         sm16[i] = 1'b0; a16[i] = '0; b16[i] = '0;
      end

      #12;
      chk("reset_busy9", 64'(busy9), 64'd0);
      chk("reset_done9", 64'(done9), 64'd0);
      chk("reset_product9", 64'(p9), 64'd0);
      chk("reset_lane0", {31'd0, busy16[0], done16[0], p16[0]}, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      run9("s7xm3", 1'b1, 9'd7, 9'h1FD, 18'h3FFEB);
      run9("smin_sq", 1'b1, 9'h100, 9'h100, 18'h10000);
      run9("umax_sq", 1'b0, 9'h1FF, 9'h1FF, 18'h3FC01);
      run9("sm1_sq", 1'b1, 9'h1FF, 9'h1FF, 18'h00001);

      // Start and operand changes while busy must not disturb the running multiply.
      sm9 = 1'b1; a9 = 9'd7; b9 = 9'h1FD; start9 = 1'b1;
      @(posedge clk); #1;
      start9 = 1'b0;
      npulse = 0;
      got = '0;
      for (int c = 1; c <= 20; c++) begin
         if (c == 3) begin start9 = 1'b1; a9 = 9'd5; b9 = 9'd6; sm9 = 1'b0; end
         if (c == 6) start9 = 1'b0;
         @(posedge clk); #1;
         if (done9) begin npulse++; got = p9; end
      end
      chk("busy_start_pulses", 64'(npulse), 64'd1);
      chk("busy_start_product", 64'(got), 64'h3FFEB);
      chk("busy_start_held", 64'(p9), 64'h3FFEB);

      // Reset in the middle of CALC aborts silently.
      sm9 = 1'b0; a9 = 9'h0AA; b9 = 9'h055; start9 = 1'b1;
      @(posedge clk); #1;
      start9 = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 64'(busy9), 64'd0);
      chk("abort_done", 64'(done9), 64'd0);
      chk("abort_product", 64'(p9), 64'd0);
      npulse = 0;
      for (int c = 1; c <= 12; c++) begin
         if (c == 3) rst_n = 1'b1;
         @(posedge clk); #1;
         if (done9) npulse++;
      end
      chk("abort_no_done", 64'(npulse), 64'd0);
      run9("after_abort", 1'b0, 9'd5, 9'd6, 18'd30);

      // WIDTH=16 random sweep, four lanes in lockstep, back-to-back operations.
      for (int op = 0; op < OPS16; op++) begin
         for (int i = 0; i < LANES; i++) begin
            sm16[i] = 1'($urandom_range(0, 1));
            a16[i]  = 16'($urandom);
            b16[i]  = 16'($urandom);
            case ($urandom_range(0, 15))
               0: a16[i] = 16'h8000;
               1: b16[i] = 16'h8000;
               2: begin a16[i] = 16'h8000; b16[i] = 16'h8000; end
               3: begin a16[i] = 16'hFFFF; b16[i] = 16'hFFFF; end
               4: a16[i] = 16'h0000;
               default: ;
            endcase
            exp16[i] = ref_mul(16, sm16[i], 32'(a16[i]), 32'(b16[i]));
         end
         start16 = 1'b1;
         @(posedge clk); #1;
         start16 = 1'b0;
         for (int i = 0; i < LANES; i++) begin
            a16[i] = 16'($urandom); b16[i] = 16'($urandom); sm16[i] = ~sm16[i];
         end
         cyc = 0;
         while (!done16[0] && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
         end
         chk("w16_latency", 64'(cyc), 64'd17);
         for (int i = 0; i < LANES; i++) begin
            chk($sformatf("w16_lane%0d_op%0d", i, op), 64'(p16[i]), exp16[i]);
         end
         @(posedge clk); #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/booth_multiplier_seq.md
BOOTH_MULTIPLIER_SEQ -- requirements
Module: booth_multiplier_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 9, giving the operand width in bits; legal values are 4..32.
REQ-002 The block SHALL have port Clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port Start, input, 1 bit: request a multiply; sampled only in IDLE.
REQ-005 The block SHALL have port Signed_Mode, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled with Start.
REQ-006 The block SHALL have port Data_A, input, WIDTH bits: multiplier operand; sampled with Start.
REQ-007 The block SHALL have port Data_B, input, WIDTH bits: multiplicand operand; sampled with Start.
REQ-008 The block SHALL have port Busy, output, 1 bit: high in CALC and DONE states.
REQ-009 The block SHALL have port Done, output, 1 bit: one-cycle pulse marking Product valid.
REQ-010 The block SHALL have port Product, output, 2*WIDTH bits: registered result, held until the next completion.

Function
REQ-011 The FSM SHALL have states IDLE, CALC and DONE.
REQ-012 The FSM SHALL make these transitions: IDLE->CALC on a Start=1 edge; CALC->DONE after the final iteration; DONE->IDLE unconditionally on the next edge.
REQ-013 On the accepting edge, the block SHALL latch the operands extended to WIDTH+1 bits: sign-extended if Signed_Mode=1, zero-extended if 0.
REQ-014 On the accepting edge, the block SHALL clear the accumulator A (WIDTH+1 bits), clear Q_-1, and load the iteration counter with N = WIDTH+1.
REQ-015 Each CALC cycle SHALL perform one radix-2 Booth step on the pair {Q0, Q_-1}.
REQ-016 In the Booth step, pair 01 SHALL give A = A + M; pair 10 SHALL give A = A - M (two's-complement add of ~M + 1); pairs 00 and 11 SHALL leave A unchanged.
REQ-017 Each Booth step SHALL then arithmetic-right-shift {A, Q, Q_-1} by one, replicating the MSB of A, and decrement the counter.
REQ-018 All Booth-step arithmetic SHALL be modulo 2^(WIDTH+1), with no overflow flag.
REQ-019 On the edge that completes iteration N, Product SHALL load bits [2*WIDTH-1:0] of {A, Q} and the state SHALL go to DONE.
REQ-020 Product SHALL be exact in both modes for all operand values, including the signed minimum times the signed minimum.
REQ-021 Latency SHALL be fixed and independent of operand values: if Start is accepted at edge k, Done SHALL be high from edge k+WIDTH+1 to edge k+WIDTH+2.
REQ-022 Start SHALL be ignored in CALC and DONE; the earliest re-accept SHALL be at the edge following DONE, giving WIDTH+3 cycles per operation back-to-back.
REQ-023 Data_A, Data_B and Signed_Mode changes after acceptance SHALL NOT affect the running operation.
REQ-024 Product SHALL change only on the completion edge; it SHALL be stable in IDLE, CALC and DONE.
REQ-025 An internal zero-initial-value simulation $display SHALL NOT be used; the result SHALL be observable only through the ports.

Reset
REQ-026 While Reset_n=0, the block SHALL immediately force state IDLE, Busy=0, Done=0, Product=0, and clear A, Q, Q_-1, M and the counter, regardless of the clock.
REQ-027 Reset asserted mid-CALC SHALL abort the operation without producing a Done pulse; after deassertion the block SHALL accept Start on the first following edge.
REQ-028 Reset deassertion SHALL be synchronised externally; the block SHALL require no clock while reset is asserted.

Verification
REQ-029 The bench SHALL check, with WIDTH=9, Signed_Mode=1, Data_A=7, Data_B=-3 (9'h1FD) -> Product=18'h3FFEB, with Done exactly 10 cycles after the Start edge.
REQ-030 The bench SHALL check, with WIDTH=9, Signed_Mode=1, Data_A=Data_B=9'h100 (-256) -> Product=18'h10000.
REQ-031 The bench SHALL check, with WIDTH=9, Signed_Mode=0, Data_A=Data_B=9'h1FF (511) -> Product=18'h3FC01; the same operands with Signed_Mode=1 -> Product=18'h00001.
REQ-032 The bench SHALL check Start pulsed with new operands during CALC -> ignored, first Product unchanged and exactly one Done pulse.
REQ-033 The bench SHALL check Reset_n low at CALC cycle 4 -> Busy=0, Product=0, no Done pulse; a Start after release with 5*6 -> Product=30.
REQ-034 The bench SHALL check, with WIDTH=16, random signed and unsigned sweeps (at least 10k vectors) against a reference model, with Done latency exactly 17 cycles.
